// File: rtl/rom_boot_copier.sv
// rom_boot_copier: copies a byte-wide ROM image into 16-bit little-endian RAM words at boot.
// Optional feature macro ROM_CHECKSUM_EN adds a modulo-256 byte checksum and option-ROM check.
module rom_boot_copier #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int RAW = 20,
    parameter logic [RAW-1:0] BASE = 20'hF8000
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           rom_ce,
    output logic [AW-1:0]  rom_address,
    input  logic [DW-1:0]  rom_data,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic [RAW-1:0] wr_address,
`ifdef ROM_CHECKSUM_EN
    output logic [7:0]     checksum,
    output logic           checksum_ok,
`endif
    output logic [15:0]    wr_data
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR, DONE} state_t;

    state_t         r_state;
    logic [AW-2:0]  r_k;
    logic [7:0]     r_lo;
    logic           r_busy;
    logic           r_done;
    logic           r_rom_ce;
    logic [AW-1:0]  r_rom_address;
    logic           r_wr_valid;
    logic [RAW-1:0] r_wr_address;
    logic [15:0]    r_wr_data;
    logic [AW-2:0]  w_k_next;
    logic           w_last;

    assign w_k_next = r_k + 1'b1;
    assign w_last   = &r_k;

    // ROM has a fixed 1-cycle read latency: byte 2k arrives in RD1, byte 2k+1 in RD2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_k           <= '0;
            r_lo          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rom_ce      <= 1'b0;
            r_rom_address <= '0;
            r_wr_valid    <= 1'b0;
            r_wr_address  <= '0;
            r_wr_data     <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_k           <= '0;
                    r_done        <= 1'b0;
                    r_busy        <= 1'b1;
                    r_rom_ce      <= 1'b1;
                    r_rom_address <= '0;
                    r_state       <= RD0;
                end
                RD0: begin
                    r_rom_address <= {r_k, 1'b1};
                    r_state       <= RD1;
                end
                RD1: begin
                    r_rom_ce <= 1'b0;
                    r_lo     <= rom_data;
                    r_state  <= RD2;
                end
                RD2: begin
                    r_wr_valid   <= 1'b1;
                    r_wr_address <= BASE + RAW'(r_k);
                    r_wr_data    <= {rom_data, r_lo};
                    r_state      <= WR;
                end
                WR: if (wr_ready) begin
                    r_wr_valid <= 1'b0;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k           <= w_k_next;
                        r_rom_ce      <= 1'b1;
                        r_rom_address <= {w_k_next, 1'b0};
                        r_state       <= RD0;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rom_ce      = r_rom_ce;
    assign rom_address = r_rom_address;
    assign wr_valid    = r_wr_valid;
    assign wr_address  = r_wr_address;
    assign wr_data     = r_wr_data;

`ifdef ROM_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_sum <= '0;
        else if (r_state == IDLE && start) r_sum <= '0;
        else if (r_state == RD1 || r_state == RD2) r_sum <= r_sum + rom_data;
    end

    // Option-ROM images are valid when all bytes sum to zero.
    assign checksum    = r_sum;
    assign checksum_ok = r_done && (r_sum == 8'h00);
`endif
endmodule

// File: tb/tb_rom_boot_copier.sv
// tb_rom_boot_copier: randomized self-checking bench for rom_boot_copier (AW=4, BASE=0x100).
module tb_rom_boot_copier;
    localparam int NW = 8;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        rom_ce;
    logic [3:0]  rom_address;
    logic [7:0]  rom_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [19:0] wr_address;
    logic [15:0] wr_data;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]  checksum;
    logic        checksum_ok;
`endif

    rom_boot_copier #(.AW(4), .DW(8), .RAW(20), .BASE(20'h00100)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rom_ce(rom_ce),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_address(wr_address),
`ifdef ROM_CHECKSUM_EN
        .checksum(checksum),
        .checksum_ok(checksum_ok),
`endif
        .wr_data(wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous ROM: data for the address presented with rom_ce appears one cycle later.
    logic [7:0] rom [0:15];
    always @(posedge clock) rom_data <= rom_ce ? rom[rom_address] : 8'($urandom);

    // Behavioural model: a copy is NW words of 4 cycles each, the write phase stretched by backpressure.
    bit m_active = 0, m_done = 0, m_post = 0, m_fresh = 1;
    int m_n = 0, m_c = 0, m_sum = 0;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 0; m_done = 0; m_post = 0; m_fresh = 1; m_n = 0; m_c = 0; m_sum = 0;
        end else if (m_active) begin
            if (m_c == 2) m_sum = (m_sum + rom[2*m_n]) % 256;
            if (m_c == 3) m_sum = (m_sum + rom[2*m_n+1]) % 256;
            if (m_c == 4) begin
                if (wr_ready) begin
                    if (m_n == NW-1) begin m_active = 0; m_done = 1; m_post = 1; end
                    else begin m_n++; m_c = 1; end
                end
            end else m_c++;
        end else if (m_post) m_post = 0;
        else if (start) begin
            m_active = 1; m_fresh = 0; m_done = 0; m_n = 0; m_c = 1; m_sum = 0;
        end
    end

    // Accepted writes as observed on the bus.
    logic [35:0] q[$];
    always @(posedge clock) if (reset_n && wr_valid && wr_ready) q.push_back({wr_address, wr_data});

    int  bp_mode = 0, bp_cnt = 0;
    bit  rand_start = 0;
    always @(negedge clock) begin
        if (bp_mode == 1) wr_ready = ($urandom_range(0, 3) != 0);
        else if (bp_mode == 2 && wr_valid && wr_address == 20'h00103 && bp_cnt < 5) begin
            wr_ready = 1'b0;
            bp_cnt++;
        end else wr_ready = 1'b1;
    end
    always @(negedge clock) if (rand_start) start = ($urandom_range(0, 5) == 0);

    int done_rises = 0, stable_cnt = 0;
    bit prev_done = 0;
    always @(negedge clock) begin
        bit exp_ce, exp_wv;
        exp_ce = m_active && (m_c == 1 || m_c == 2);
        exp_wv = m_active && m_c == 4;
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("rom_ce", rom_ce, exp_ce);
        chk("wr_valid", wr_valid, exp_wv);
        if (exp_ce) chk("rom_address", rom_address, 64'(2*m_n + m_c - 1));
        if (exp_wv) begin
            chk("wr_address", wr_address, 64'(32'h100 + m_n));
            chk("wr_data", wr_data, {rom[2*m_n+1], rom[2*m_n]});
        end
        if (m_fresh) begin
            chk("rst_rom_address", rom_address, 0);
            chk("rst_wr_address", wr_address, 0);
            chk("rst_wr_data", wr_data, 0);
        end
`ifdef ROM_CHECKSUM_EN
        chk("checksum", checksum, 64'(m_sum));
        chk("checksum_ok", checksum_ok, m_done && m_sum == 0);
`endif
        if (wr_valid && wr_address == 20'h00103 && wr_data == 16'h0706) stable_cnt++;
        if (done && !prev_done) done_rises++;
        prev_done = done;
    end

    // cyc counts rising edges from the start-sampling edge until done is seen.
    task automatic run_copy(output int cyc);
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0; cyc = 0;
        while (!done && cyc < 300) begin @(negedge clock); cyc++; end
        repeat (2) @(negedge clock);
    endtask

    int cyc, rises0, n;
    initial begin
        reset_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_ce", rom_ce, 0);
        chk("rst_wr_valid", wr_valid, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("idle_busy", busy, 0);
        chk("idle_wr_valid", wr_valid, 0);

        q.delete();
        run_copy(cyc);
        chk("basic_time", cyc, 32);
        chk("basic_count", q.size(), 8);
        if (q.size() == 8) begin
            chk("basic_w0", q[0], {20'h00100, 16'h0100});
            chk("basic_w7", q[7], {20'h00107, 16'h0F0E});
        end

        bp_mode = 2; bp_cnt = 0; stable_cnt = 0; q.delete();
        run_copy(cyc);
        bp_mode = 0;
        chk("bp_time", cyc, 37);
        chk("bp_stable", stable_cnt, 6);
        chk("bp_count", q.size(), 8);
        if (q.size() == 8) chk("bp_w3", q[3], {20'h00103, 16'h0706});

        q.delete(); rises0 = done_rises;
        fork
            run_copy(cyc);
            begin repeat (10) @(negedge clock); start = 1'b1; @(negedge clock); start = 1'b0; end
        join
        repeat (40) @(negedge clock);
        chk("busy_start_time", cyc, 32);
        chk("busy_start_count", q.size(), 8);
        chk("busy_start_rises", done_rises - rises0, 1);

        q.delete();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        n = 0;
        while (!(wr_valid && wr_address == 20'h00102) && n < 100) begin @(negedge clock); n++; end
        chk("mid_reached", n < 100, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_wr_valid", wr_valid, 0);
        chk("mid_wr_address", wr_address, 0);
        chk("mid_wr_data", wr_data, 0);
        chk("mid_rom_ce", rom_ce, 0);
        chk("mid_count", q.size(), 2);
        @(negedge clock); reset_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("mid_after_count", q.size(), 2);
        q.delete();
        run_copy(cyc);
        chk("recopy_time", cyc, 32);
        chk("recopy_count", q.size(), 8);
        if (q.size() > 0) chk("recopy_w0", q[0], {20'h00100, 16'h0100});

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            bp_mode = 1; rand_start = 1;
            repeat (600) @(negedge clock);
            rand_start = 0; start = 1'b0; bp_mode = 0;
            n = 0;
            while (busy && n < 300) begin @(negedge clock); n++; end
            chk("rand_drain", busy, 0);
            repeat (3) @(negedge clock);
        end

`ifdef ROM_CHECKSUM_EN
        for (int i = 0; i < 15; i++) rom[i] = 8'h01;
        rom[15] = 8'hF1;
        run_copy(cyc);
        chk("cs_zero", checksum, 8'h00);
        chk("cs_ok", checksum_ok, 1);
        rom[0] = 8'h02;
        run_copy(cyc);
        chk("cs_one", checksum, 8'h01);
        chk("cs_bad", checksum_ok, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
